// File: rtl/hs_driver_if.sv
// hs_driver block bus: ap_* handshake plus score/argmax readout.
// master = accelerator side (drives results), slave = host side (drives start).
interface hs_driver_if;
  logic               i_ap_start;
  logic               o_ap_idle;
  logic               o_ap_ready;
  logic               o_ap_done;
  logic        [31:0] acc_out_addr;
  logic signed [15:0] acc_out_data;
  logic               o_max_v;
  logic         [4:0] o_max_lbl;

  modport master (
    input  i_ap_start,
    output o_ap_idle,
    output o_ap_ready,
    output o_ap_done,
    output acc_out_addr,
    output acc_out_data,
    output o_max_v,
    output o_max_lbl
  );

  modport slave (
    output i_ap_start,
    input  o_ap_idle,
    input  o_ap_ready,
    input  o_ap_done,
    input  acc_out_addr,
    input  acc_out_data,
    input  o_max_v,
    input  o_max_lbl
  );
endinterface

// File: rtl/hs_driver.sv
// hs_driver: ap_* accelerator model; waits COMPUTE_LAT, streams NUM_OUT
// scores as addr/data, then pulses done/ready/max_v with the argmax label.
// Ports: aclk, aresetn (async, active-low), bus (hs_driver_if.master).
module hs_driver #(
  parameter int          NUM_OUT     = 10,
  parameter int          COMPUTE_LAT = 16,
  parameter int          PEAK_IDX    = 7,
  parameter int unsigned ADDR_BASE   = 0
) (
  input  logic          aclk,
  input  logic          aresetn,
  hs_driver_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_STREAM,
    S_DONE
  } state_t;

  // Built-in score curve, wraps modulo 2^16.
  function automatic logic signed [15:0] score(
    input logic [5:0] i
  );
    int d;
    int v;
    d = int'(i) - PEAK_IDX;
    v = 1000 - 10 * d * d;
    return 16'(v);
  endfunction

  state_t             state_q, state_d;
  logic        [31:0] cnt_q, cnt_d;
  logic         [5:0] idx_q, idx_d;
  logic signed [15:0] max_q, max_d;
  logic         [4:0] arg_q, arg_d;
  logic               idle_q, idle_d;
  logic               done_q, done_d;
  logic         [4:0] lbl_q, lbl_d;
  logic        [31:0] addr_q, addr_d;
  logic signed [15:0] data_q, data_d;

  logic               emit;
  logic         [5:0] emit_idx;
  logic signed [15:0] emit_val;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    max_d    = max_q;
    arg_d    = arg_q;
    done_d   = 1'b0;
    lbl_d    = lbl_q;
    addr_d   = addr_q;
    data_d   = data_q;
    emit     = 1'b0;
    emit_idx = idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_ap_start) begin
          state_d = S_CALC;
          cnt_d   = '0;
          max_d   = 16'sh8000;
          arg_d   = '0;
        end
      end
      S_CALC: begin
        // Last CALC edge already registers score[0].
        if (cnt_q == 32'(COMPUTE_LAT - 1)) begin
          state_d  = S_STREAM;
          emit     = 1'b1;
          emit_idx = '0;
          idx_d    = 6'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_STREAM: begin
        if (idx_q == 6'(NUM_OUT)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          lbl_d   = arg_q;
          addr_d  = ADDR_BASE + {27'd0, arg_q};
          data_d  = max_q;
        end else begin
          emit  = 1'b1;
          idx_d = idx_q + 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    emit_val = score(emit_idx);
    if (emit) begin
      addr_d = ADDR_BASE + {26'd0, emit_idx};
      data_d = emit_val;
      // Strict compare: ties keep the lowest index.
      if (emit_val > max_q) begin
        max_d = emit_val;
        arg_d = emit_idx[4:0];
      end
    end

    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      arg_q   <= '0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      lbl_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      arg_q   <= arg_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      lbl_q   <= lbl_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_ap_idle    = idle_q;
  assign bus.o_ap_ready   = done_q;
  assign bus.o_ap_done    = done_q;
  assign bus.o_max_v      = done_q;
  assign bus.o_max_lbl    = lbl_q;
  assign bus.acc_out_addr = addr_q;
  assign bus.acc_out_data = data_q;

endmodule

// File: tb/tb_hs_driver.sv
// tb_hs_driver: four hs_driver configs checked each cycle against a
// timeline model, plus a vector table and hand-written corner sequences.
module tb_hs_driver;

  function automatic int pn(input int k);
    return (k == 0) ? 10 : (k == 3) ? 32 : 3;
  endfunction
  function automatic int pl(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : (k == 2) ? 2 : 1;
  endfunction
  function automatic int pp(input int k);
    return (k == 0) ? 7 : (k == 2) ? 1 : 0;
  endfunction
  function automatic int pb(input int k);
    return (k == 2) ? 16 : (k == 3) ? 100 : 0;
  endfunction

  function automatic int ref_score(input int k, input int i);
    int d;
    int v;
    d = i - pp(k);
    v = (1000 - 10 * d * d) & 32'hffff;
    if (v >= 32768) v = v - 65536;
    return v;
  endfunction
  function automatic int ref_arg(input int k);
    int best;
    int a;
    best = -40000;
    a = 0;
    for (int i = 0; i < pn(k); i++)
      if (ref_score(k, i) > best) begin
        best = ref_score(k, i);
        a = i;
      end
    return a;
  endfunction

  logic clk;
  logic rst_n;
  logic [3:0] st;

  logic               a_idle[4];
  logic               a_rdy[4];
  logic               a_done[4];
  logic               a_mv[4];
  logic         [4:0] a_lbl[4];
  logic        [31:0] a_addr[4];
  logic signed [15:0] a_data[4];

  hs_driver_if ifs[4] ();

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign ifs[g].i_ap_start = st[g];
    assign a_idle[g] = ifs[g].o_ap_idle;
    assign a_rdy[g]  = ifs[g].o_ap_ready;
    assign a_done[g] = ifs[g].o_ap_done;
    assign a_mv[g]   = ifs[g].o_max_v;
    assign a_lbl[g]  = ifs[g].o_max_lbl;
    assign a_addr[g] = ifs[g].acc_out_addr;
    assign a_data[g] = ifs[g].acc_out_data;
    hs_driver #(
      .NUM_OUT    (pn(g)),
      .COMPUTE_LAT(pl(g)),
      .PEAK_IDX   (pp(g)),
      .ADDR_BASE  (pb(g))
    ) u_dut (
      .aclk   (clk),
      .aresetn(rst_n),
      .bus    (ifs[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k,
                     input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s[%0d]: got %0d want %0d", nm, k, act, exp);
    end
  endtask

  // Timeline model: t counts edges since the accepting edge.
  bit                 m_run[4];
  int                 m_t[4];
  logic               e_idle[4];
  logic               e_pulse[4];
  logic         [4:0] e_lbl[4];
  logic        [31:0] e_addr[4];
  logic signed [15:0] e_data[4];

  always @(posedge clk or negedge rst_n) begin
    int n;
    int l;
    int t;
    int a;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_run[k]   <= 1'b0;
        m_t[k]     <= 0;
        e_idle[k]  <= 1'b1;
        e_pulse[k] <= 1'b0;
        e_lbl[k]   <= '0;
        e_addr[k]  <= '0;
        e_data[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        n = pn(k);
        l = pl(k);
        t = m_t[k] + 1;
        a = ref_arg(k);
        e_pulse[k] <= 1'b0;
        if (!m_run[k]) begin
          if (st[k]) begin
            m_run[k]  <= 1'b1;
            m_t[k]    <= 0;
            e_idle[k] <= 1'b0;
          end
        end else begin
          m_t[k] <= t;
          if (t >= l && t < l + n) begin
            e_addr[k] <= 32'(pb(k) + t - l);
            e_data[k] <= 16'(ref_score(k, t - l));
          end else if (t == l + n) begin
            e_pulse[k] <= 1'b1;
            e_lbl[k]   <= 5'(a);
            e_addr[k]  <= 32'(pb(k) + a);
            e_data[k]  <= 16'(ref_score(k, a));
          end else if (t == l + n + 1) begin
            m_run[k]  <= 1'b0;
            e_idle[k] <= 1'b1;
          end
        end
      end
    end
  end

  bit chk_en = 0;
  int cap_data[4][32];
  int cap_lbl[4];

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk("idle",  k, int'(a_idle[k]), int'(e_idle[k]));
        chk("ready", k, int'(a_rdy[k]),  int'(e_pulse[k]));
        chk("done",  k, int'(a_done[k]), int'(e_pulse[k]));
        chk("max_v", k, int'(a_mv[k]),   int'(e_pulse[k]));
        chk("lbl",   k, int'(a_lbl[k]),  int'(e_lbl[k]));
        chk("addr",  k, int'(a_addr[k]), int'(e_addr[k]));
        chk("data",  k, int'(a_data[k]), int'(e_data[k]));
        if (m_run[k] && m_t[k] >= pl(k) && m_t[k] < pl(k) + pn(k))
          cap_data[k][m_t[k] - pl(k)] = int'(a_data[k]);
        if (e_pulse[k]) cap_lbl[k] = int'(a_lbl[k]);
      end
    end
  end

  typedef struct {
    int k;
    int kind;
    int idx;
    int exp;
  } vec_t;

  vec_t tbl[$];

  int cnt;
  int first;
  int second;
  int pulses;
  bit found;

  initial begin
    int v0[10];
    v0 = '{510, 640, 750, 840, 910, 960, 990, 1000, 990, 960};
    for (int i = 0; i < 10; i++) tbl.push_back('{0, 0, i, v0[i]});
    tbl.push_back('{0, 1, 0, 7});
    tbl.push_back('{1, 0, 0, 1000});
    tbl.push_back('{1, 0, 1, 990});
    tbl.push_back('{1, 0, 2, 960});
    tbl.push_back('{1, 1, 0, 0});
    tbl.push_back('{2, 0, 0, 990});
    tbl.push_back('{2, 0, 1, 1000});
    tbl.push_back('{2, 0, 2, 990});
    tbl.push_back('{2, 1, 0, 1});
    tbl.push_back('{3, 0, 0, 1000});
    tbl.push_back('{3, 0, 31, -8610});
    tbl.push_back('{3, 1, 0, 0});

    for (int k = 0; k < 4; k++) begin
      cap_lbl[k] = -1;
      for (int i = 0; i < 32; i++) cap_data[k][i] = -99999;
    end

    st = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_en = 1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    // Nominal run on the default config, latency measured by hand.
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    cnt = 0;
    found = 0;
    while (!found && cnt < 100) begin
      @(negedge clk);
      #3;
      cnt++;
      if (a_mv[0]) found = 1;
    end
    chk("done_latency", 0, cnt, 26);
    repeat (5) @(negedge clk);

    // Other configs run together.
    st[3:1] = 3'b111;
    @(negedge clk);
    st[3:1] = 3'b000;
    repeat (60) @(negedge clk);

    foreach (tbl[j]) begin
      if (tbl[j].kind == 0)
        chk("tbl_data", tbl[j].k, cap_data[tbl[j].k][tbl[j].idx],
            tbl[j].exp);
      else
        chk("tbl_lbl", tbl[j].k, cap_lbl[tbl[j].k], tbl[j].exp);
    end

    // Start held high: back-to-back runs, 28-cycle period.
    st[0] = 1'b1;
    pulses = 0;
    first = -1;
    second = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      #3;
      if (a_mv[0]) begin
        pulses++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    @(negedge clk);
    st[0] = 1'b0;
    chk("long_first", 0, first - 1, 26);
    chk("long_gap", 0, second - first, 28);
    chk("long_pulses", 0, pulses, 3);
    repeat (40) @(negedge clk);

    // Reset while streaming index 4.
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (m_run[0] && m_t[0] == pl(0) + 4) found = 1;
    end
    chk("reach_idx4", 0, int'(found), 1);
    chk("pre_rst_addr", 0, int'(a_addr[0]), 4);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_addr", 0, int'(a_addr[0]), 0);
    chk("rst_data", 0, int'(a_data[0]), 0);
    chk("rst_idle", 0, int'(a_idle[0]), 1);
    chk("rst_mv", 0, int'(a_mv[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #3;
      if (a_mv[0] || a_done[0]) pulses++;
    end
    chk("no_partial_done", 0, pulses, 0);
    cap_lbl[0] = -1;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (35) @(negedge clk);
    chk("rerun_lbl", 0, cap_lbl[0], 7);

    // Random start traffic with rare async resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        st[k] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    st = '0;
    repeat (50) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hs_driver.md
Name: hs_driver

Overview:
- Self-contained accelerator model with an HLS-style ap_* block-level handshake (ap_start/ap_idle/ap_ready/ap_done).
- On start it spends a fixed compute latency, then streams NUM_OUT signed 16-bit class scores one per cycle as address/data pairs.
- It tracks the running maximum and, at the end, reports the argmax label with a one-cycle valid pulse.
- Serves as the result-readout stage of the CNN accelerator simulation flow.

Parameters:
- NUM_OUT, 10, number of scores per run; range 1..32 (label is 5 bits).
- COMPUTE_LAT, 16, cycles spent in CALC before streaming; minimum 1.
- PEAK_IDX, 7, index of the peak of the built-in score curve; must be < NUM_OUT.
- ADDR_BASE, 0, added to the score index to form acc_out_addr.

Ports:
- aclk  in  1  sole clock, rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- i_ap_start  in  1  level start request.
- o_ap_idle  out  1  high while in IDLE.
- o_ap_ready  out  1  one-cycle pulse at run end.
- o_ap_done  out  1  one-cycle pulse at run end.
- acc_out_addr  out  32  ADDR_BASE + score index, zero-extended.
- acc_out_data  out  16  signed score.
- o_max_v  out  1  one-cycle pulse; max result valid.
- o_max_lbl  out  5  argmax index.

Behaviour:
- One clock domain (aclk); reset is asynchronous and active-low on aresetn. All outputs are registered.
- Reset values:
  - o_ap_idle = 1.
  - o_ap_ready, o_ap_done, o_max_v, o_max_lbl, acc_out_addr, acc_out_data = 0.
  - State = IDLE; running max cleared.
- Score ROM is combinational, fixed at elaboration: score[i] = 1000 - 10*(i-PEAK_IDX)^2, signed 16-bit, two's complement, wraps modulo 2^16.
- FSM states: IDLE, CALC, STREAM, DONE.
- IDLE:
  - o_ap_idle = 1.
  - A clock edge sampling i_ap_start=1 is the accepting edge: go to CALC, clear the cycle counter, set running max to -32768 and argmax to 0.
  - i_ap_start is ignored in every other state.
- CALC:
  - o_ap_idle = 0; lasts exactly COMPUTE_LAT cycles.
  - Output buses hold their previous values.
- STREAM:
  - Lasts NUM_OUT cycles. On cycle i (0-based) the outputs show acc_out_addr = ADDR_BASE+i and acc_out_data = score[i].
  - The first STREAM value is registered at accepting edge + COMPUTE_LAT.
  - Running max updates only when score[i] is strictly greater than the current max, so ties keep the lowest index.
- DONE:
  - One cycle, registered at accepting edge + COMPUTE_LAT + NUM_OUT.
  - o_max_v = o_ap_done = o_ap_ready = 1.
  - o_max_lbl = argmax; acc_out_addr = ADDR_BASE + argmax; acc_out_data = max.
  - Next state is IDLE unconditionally, so there is always at least one idle cycle between runs.
- After DONE:
  - o_max_lbl, acc_out_addr and acc_out_data hold until the next run overwrites them or reset.
  - Pulse outputs return to 0.
- i_ap_start held high continuously: the block re-accepts on the edge after returning to IDLE. This is a back-to-back rerun with identical results.
- Reset asserted mid-run: immediate return to reset values; a partial run produces no o_max_v or o_ap_done.
- o_ap_done, o_ap_ready and o_max_v are always coincident and exactly one cycle wide.
- NUM_OUT=1: argmax = 0; DONE follows a single STREAM cycle.

Test Plan:
- Reset then idle: hold aresetn low 10 cycles, release with i_ap_start=0 for 100 cycles -> o_ap_idle=1 throughout; all other outputs 0.
- Nominal run with defaults: pulse i_ap_start for 1 cycle ->
  - o_ap_idle falls;
  - 16 cycles later addr 0..9 stream data 510, 640, 750, 840, 910, 960, 990, 1000, 990, 960;
  - next cycle o_max_v = o_ap_done = o_ap_ready = 1, o_max_lbl = 7, addr = 7, data = 1000;
  - o_ap_idle=1 the cycle after.
- Long start: hold i_ap_start high 100 cycles -> first o_max_v 26 cycles after the accepting edge; a second identical run starts one idle cycle later; never more than one run in flight.
- Tie-break: PEAK_IDX=0, NUM_OUT=3 -> data 1000, 990, 960; o_max_lbl=0. Symmetric case PEAK_IDX=1, NUM_OUT=3 -> 990, 1000, 990; o_max_lbl=1 (strict greater-than; the equal later value does not win).
- Reset mid-STREAM: assert aresetn low at stream index 4 -> outputs return to 0 asynchronously; no o_max_v. A fresh start afterwards yields o_max_lbl=7.
- Wrap/negative: PEAK_IDX=0, NUM_OUT=32 -> score[31] = 1000 - 9610 = -8610 (signed). Max is still label 0; no overflow in the comparison.
